jt51_wrsched: RTL
=================

// Module: jt51_wrsched
// PURPOSE
//  Write scheduler for the jt51_reg register bank. Arbitrates YM2151 register writes from the CPU
//  bus and a secondary sequencer port and queues them in a small FIFO. Decodes each write to one
//  up_* strobe plus op/ch, and holds it through jt51_reg's 32-slot busy round. Non-bank addresses
//  (test, noise, timers, LFO, CT) go to a one-cycle side port.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2
//  WDOG    96  cen ticks to wait for reg_busy rise before abort
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  cen        in   1   clock enable, same cen as jt51_reg (P1)
//  cpu_valid  in   1   CPU write request
//  cpu_addr   in   8   CPU register address
//  cpu_din    in   8   CPU data
//  cpu_ready  out  1   CPU request accepted this cycle
//  seq_valid  in   1   sequencer write request
//  seq_addr   in   8   sequencer address
//  seq_din    in   8   sequencer data
//  seq_ready  out  1   sequencer request accepted this cycle
//  reg_busy   in   1   busy from jt51_reg
//  d_in       out  8   data to jt51_reg
//  up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_keyon
//             out  1 each  one-hot update strobes to jt51_reg
//  op         out  2   operator index (addr[4:3])
//  ch         out  3   channel index (addr[2:0])
//  side_wr    out  1   one-cen pulse for non-bank addresses
//  side_addr  out  8   side-port address
//  side_din   out  8   side-port data
//  wr_busy    out  1   FIFO non-empty or write in flight (status bit 7)
//  wdog_err   out  1   sticky watchdog abort flag; cleared by rst only
// BEHAVIOUR
//  - All state advances only when cen=1. Reset: FIFO empty, FSM IDLE, all up_* low, d_in/op/ch=0,
//    side_wr=0, wr_busy=0, wdog_err=0, RR pointer=CPU. Reset mid-write drops strobes at once.
//  - Acceptance: *_ready = !full && rr_grant. Both valid: the RR pointer wins, and the pointer flips
//    after each grant. One valid: it wins. FIFO full: both ready=0. At most one push per cen.
//  - Decode at pop:
//    08 keyon; 20-27 rl; 28-2F kc; 30-37 kf; 38-3F pms; 40-5F dt1; 60-7F tl; 80-9F ks; A0-BF amsen;
//    C0-DF dt2; E0-FF d1l. op=addr[4:3], ch=addr[2:0]; keyon uses op=0, ch=0.
//  - All other addresses are side writes.
//  - FSM:
//    IDLE: FIFO non-empty -> pop. Side address -> side_wr pulse, stay IDLE (1 pop/cen).
//          Bank address -> drive d_in/op/ch and one strobe, go ARM.
//    ARM: hold outputs; reg_busy=1 -> HOLD. WDOG ticks without busy -> drop strobe, set wdog_err,
//         go IDLE.
//    HOLD: hold outputs; reg_busy=0 -> clear strobe, go GAP.
//    GAP: one tick with all up_* low, so jt51_reg cannot re-latch the same write; -> IDLE.
//  - Outputs (d_in, op, ch, up_*) stay stable from ARM entry to HOLD exit. Exactly one up_* is high
//    in ARM/HOLD; none in IDLE/GAP.
//  - Latency: a push into an empty FIFO reaches ARM on the next cen. Bank writes take <=66 cen ticks
//    (up to 33 waiting for slot 31, plus 32 busy, plus GAP).
//  - wr_busy = !empty || state!=IDLE || side_wr.
//  - FIFO: pointers are log2(DEPTH)+1 bits. Full when MSBs differ and LSBs are equal. Push and pop
//    in the same cen on a full FIFO is legal, and full stays asserted. Push to an empty FIFO is
//    never bypassed.
// STRUCTURE
//  - Shared include jt51_regs.vh: address-range localparams (ADDR_KON=8'h08, ADDR_RL=8'h20, ...,
//    ADDR_D1L=8'hE0) and an 11-bit strobe-index enum; reused by the CPU interface and the tests.
//  - Sub-module jt51_wrfifo: DEPTH x 16-bit sync FIFO with push/pop/full/empty.
//  - Decode and FSM live in this file.
// TESTING
//  1. CPU writes 20h=C7 alone -> up_rl=1, ch=0, d_in=C7 held until reg_busy falls. One GAP tick
//     follows, and jt51_reg reads rl=3, fb=0, con=7 for ch0.
//  2. Both ports valid on the same cen: CPU 28h=4A, seq 29h=3C -> CPU granted first, seq next cen.
//     Strobes issue in order, with kc ch0=4A then ch1=3C.
//  3. Fill the FIFO with DEPTH writes while in HOLD -> cpu_ready=0 on the next push. After one pop,
//     ready=1. All DEPTH writes land in order.
//  4. Write 14h=15 then 60h=7F -> side_wr pulses once with 14/15 and no up_*. Then up_tl=1, op=0,
//     ch=0, and wr_busy deasserts after GAP.
//  5. Hold reg_busy=0 permanently during a 08h write -> abort after WDOG=96 ticks, wdog_err=1,
//     strobe low, next FIFO entry proceeds.
//  6. Assert rst while in HOLD -> next cycle all up_* low, FIFO empty, wr_busy=0, cpu_ready=1.

Source files
------------

// File: rtl/jt51_wrsched_pkg.sv
// Shared definitions for the jt51 write scheduler: register-bank address map,
// strobe indices, FSM states and the address decoder.
package jt51_wrsched_pkg;

    localparam logic [7:0] ADDR_KON   = 8'h08;
    localparam logic [7:0] ADDR_RL    = 8'h20;
    localparam logic [7:0] ADDR_KC    = 8'h28;
    localparam logic [7:0] ADDR_KF    = 8'h30;
    localparam logic [7:0] ADDR_PMS   = 8'h38;
    localparam logic [7:0] ADDR_DT1   = 8'h40;
    localparam logic [7:0] ADDR_TL    = 8'h60;
    localparam logic [7:0] ADDR_KS    = 8'h80;
    localparam logic [7:0] ADDR_AMSEN = 8'hA0;
    localparam logic [7:0] ADDR_DT2   = 8'hC0;
    localparam logic [7:0] ADDR_D1L   = 8'hE0;

    localparam int NSTB = 11;

    typedef enum logic [3:0] {
        STB_RL    = 4'd0,
        STB_KC    = 4'd1,
        STB_KF    = 4'd2,
        STB_PMS   = 4'd3,
        STB_DT1   = 4'd4,
        STB_TL    = 4'd5,
        STB_KS    = 4'd6,
        STB_AMSEN = 4'd7,
        STB_DT2   = 4'd8,
        STB_D1L   = 4'd9,
        STB_KEYON = 4'd10
    } stb_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HOLD = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    typedef struct packed {
        logic       bank;
        stb_e       stb;
        logic [1:0] op;
        logic [2:0] ch;
    } dec_t;

    // Anything below 0x20 other than key-on belongs to the side port.
    function automatic dec_t decode(input logic [7:0] addr);
        dec_t r;
        r.bank = 1'b1;
        r.stb  = STB_RL;
        r.op   = addr[4:3];
        r.ch   = addr[2:0];
        if (addr == ADDR_KON) begin
            r.stb = STB_KEYON;
            r.op  = 2'd0;
            r.ch  = 3'd0;
        end
        else if (addr >= ADDR_D1L)   r.stb = STB_D1L;
        else if (addr >= ADDR_DT2)   r.stb = STB_DT2;
        else if (addr >= ADDR_AMSEN) r.stb = STB_AMSEN;
        else if (addr >= ADDR_KS)    r.stb = STB_KS;
        else if (addr >= ADDR_TL)    r.stb = STB_TL;
        else if (addr >= ADDR_DT1)   r.stb = STB_DT1;
        else if (addr >= ADDR_PMS)   r.stb = STB_PMS;
        else if (addr >= ADDR_KF)    r.stb = STB_KF;
        else if (addr >= ADDR_KC)    r.stb = STB_KC;
        else if (addr >= ADDR_RL)    r.stb = STB_RL;
        else                         r.bank = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/jt51_wrfifo.sv
// Small synchronous FIFO holding {addr, data} write requests.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module jt51_wrfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push on a full FIFO is allowed then.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end

    assign dout  = mem_q[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/jt51_wrsched.sv
// Write scheduler for the jt51 register bank: arbitrates CPU and sequencer
// writes, queues them, and holds each bank write through one busy round.
module jt51_wrsched
    import jt51_wrsched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WDOG  = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cpu_valid,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic       cpu_ready,
    input  logic       seq_valid,
    input  logic [7:0] seq_addr,
    input  logic [7:0] seq_din,
    output logic       seq_ready,
    input  logic       reg_busy,
    output logic [7:0] d_in,
    output logic       up_rl,
    output logic       up_kc,
    output logic       up_kf,
    output logic       up_pms,
    output logic       up_dt1,
    output logic       up_tl,
    output logic       up_ks,
    output logic       up_amsen,
    output logic       up_dt2,
    output logic       up_d1l,
    output logic       up_keyon,
    output logic [1:0] op,
    output logic [2:0] ch,
    output logic       side_wr,
    output logic [7:0] side_addr,
    output logic [7:0] side_din,
    output logic       wr_busy,
    output logic       wdog_err
);
    localparam int                WCW       = $clog2(WDOG);
    localparam logic [WCW-1:0]    WDOG_LAST = WCW'(WDOG - 1);
    localparam logic [NSTB-1:0]   STB_ONE   = NSTB'(1);

    logic            full, empty, push, pop;
    logic [15:0]     fifo_din, fifo_dout;
    logic            grant_cpu, grant_seq;
    logic            rr_q, rr_d;          // 0: CPU has priority, 1: sequencer
    dec_t            dec;

    state_e          state_q, state_d;
    logic [NSTB-1:0] up_q, up_d;
    logic [7:0]      d_in_q, d_in_d;
    logic [1:0]      op_q, op_d;
    logic [2:0]      ch_q, ch_d;
    logic            side_wr_q, side_wr_d;
    logic [7:0]      side_addr_q, side_addr_d;
    logic [7:0]      side_din_q, side_din_d;
    logic [WCW-1:0]  wdog_q, wdog_d;
    logic            wdog_err_q, wdog_err_d;

    assign grant_cpu = cpu_valid && (!seq_valid || !rr_q);
    assign grant_seq = seq_valid && (!cpu_valid ||  rr_q);
    assign cpu_ready = cen && !full && grant_cpu;
    assign seq_ready = cen && !full && grant_seq;
    assign push      = cpu_ready || seq_ready;
    assign fifo_din  = cpu_ready ? {cpu_addr, cpu_din} : {seq_addr, seq_din};
    assign rr_d      = push ? ~rr_q : rr_q;

    jt51_wrfifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign dec = decode(fifo_dout[15:8]);

    always_comb begin
        state_d     = state_q;
        up_d        = up_q;
        d_in_d      = d_in_q;
        op_d        = op_q;
        ch_d        = ch_q;
        side_wr_d   = 1'b0;
        side_addr_d = side_addr_q;
        side_din_d  = side_din_q;
        wdog_d      = wdog_q;
        wdog_err_d  = wdog_err_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cen && !empty) begin
                    pop = 1'b1;
                    if (dec.bank) begin
                        up_d    = STB_ONE << dec.stb;
                        d_in_d  = fifo_dout[7:0];
                        op_d    = dec.op;
                        ch_d    = dec.ch;
                        wdog_d  = '0;
                        state_d = ST_ARM;
                    end else begin
                        side_wr_d   = 1'b1;
                        side_addr_d = fifo_dout[15:8];
                        side_din_d  = fifo_dout[7:0];
                    end
                end
            end
            ST_ARM: begin
                if (reg_busy) begin
                    state_d = ST_HOLD;
                end else if (wdog_q == WDOG_LAST) begin
                    up_d       = '0;
                    wdog_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!reg_busy) begin
                    up_d    = '0;
                    state_d = ST_GAP;
                end
            end
            // Strobes stay low for a full tick so the bank cannot re-latch.
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            up_q        <= '0;
            d_in_q      <= '0;
            op_q        <= '0;
            ch_q        <= '0;
            side_wr_q   <= 1'b0;
            side_addr_q <= '0;
            side_din_q  <= '0;
            wdog_q      <= '0;
            wdog_err_q  <= 1'b0;
            rr_q        <= 1'b0;
        end else if (cen) begin
            state_q     <= state_d;
            up_q        <= up_d;
            d_in_q      <= d_in_d;
            op_q        <= op_d;
            ch_q        <= ch_d;
            side_wr_q   <= side_wr_d;
            side_addr_q <= side_addr_d;
            side_din_q  <= side_din_d;
            wdog_q      <= wdog_d;
            wdog_err_q  <= wdog_err_d;
            rr_q        <= rr_d;
        end
    end

    assign up_rl     = up_q[STB_RL];
    assign up_kc     = up_q[STB_KC];
    assign up_kf     = up_q[STB_KF];
    assign up_pms    = up_q[STB_PMS];
    assign up_dt1    = up_q[STB_DT1];
    assign up_tl     = up_q[STB_TL];
    assign up_ks     = up_q[STB_KS];
    assign up_amsen  = up_q[STB_AMSEN];
    assign up_dt2    = up_q[STB_DT2];
    assign up_d1l    = up_q[STB_D1L];
    assign up_keyon  = up_q[STB_KEYON];
    assign d_in      = d_in_q;
    assign op        = op_q;
    assign ch        = ch_q;
    assign side_wr   = side_wr_q;
    assign side_addr = side_addr_q;
    assign side_din  = side_din_q;
    assign wdog_err  = wdog_err_q;
    assign wr_busy   = !empty || (state_q != ST_IDLE) || side_wr_q;

endmodule
